// File: rtl/apb_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
// Shared types and defaults for the APB3 master bridge.
//   apb_state_e : bridge FSM states (IDLE, SETUP, ACCESS)
//   apb_rsp_t   : response bundle returned to the requester (rdata, err)
//   APB_DEF_*   : default address / data widths
// ---------------------------------------------------------------------------
package apb_master_pkg;

  localparam int unsigned APB_DEF_ADDR_WIDTH = 32;
  localparam int unsigned APB_DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DEF_DATA_WIDTH-1:0] rdata;
    logic                          err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
// Saturating count of ACCESS cycles spent waiting on PREADY.
//   clk_i         : clock
//   rst_i         : synchronous active-high reset
//   clear_i       : zero the counter (takes priority over enable_i)
//   enable_i      : current cycle is an ACCESS wait cycle
//   timeout_hit_o : this wait cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_hit_o
);

  localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of earlier wait cycles, so the counter reaches
  // TIMEOUT with the current one when count_q is TIMEOUT-1.
  assign timeout_hit_o = enable_i && (count_q >= LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Converts a valid/ready request interface into APB3 SETUP/ACCESS transfers
// and returns a one-cycle response pulse (read data + error).
//
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that has seen
// TIMEOUT cycles of PREADY=0 (response with rsp_err=1, rsp_rdata=0).
// Without it the bridge waits indefinitely.
//
// Ports:
//   PCLK, PRESET          : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_write/addr/wdata  : request payload
//   rsp_valid/rdata/err   : one-cycle response (not backpressured)
//   PSEL..PWDATA          : APB master outputs (registered)
//   PRDATA/PREADY/PSLVERR : APB slave returns
// ---------------------------------------------------------------------------
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 10
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("apb_master_bridge: TIMEOUT must be at least 1");
  end

  apb_state_e            state_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  accept;
  logic                  timeout_hit;

  // Acceptance in ACCESS only on the completion cycle gives back-to-back
  // transfers with PSEL held high.
  assign req_ready = !PRESET &&
                     ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
  assign accept    = req_valid && req_ready;

`ifdef APB_TIMEOUT_EN
  logic wait_cycle;

  assign wait_cycle = (state_q == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i        (PCLK),
    .rst_i        (PRESET),
    .clear_i      (!wait_cycle),
    .enable_i     (wait_cycle),
    .timeout_hit_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            pwrite_q  <= req_write;
            paddr_q   <= req_addr;
            pwdata_q  <= req_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            if (accept) begin
              pwrite_q  <= req_write;
              paddr_q   <= req_addr;
              pwdata_q  <= req_wdata;
              penable_q <= 1'b0;
              state_q   <= SETUP;
            end else begin
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 10;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic put_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick(); tick();
    vecs++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
    end
    vecs++;
    if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
      errs++; $display("FAIL reset_data: got %h/%h/%h expected all zero", PADDR, PWDATA, rsp_rdata);
    end
    req_valid = 1'b1; #1;
    vecs++;
    if (req_ready !== 1'b0) begin
      errs++; $display("FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    req_valid = 1'b0; PRESET = 1'b0; #1;
    vecs++;
    if (req_ready !== 1'b1) begin
      errs++; $display("FAIL idle_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_single_write;
    PREADY = 1'b1;
    put_req(1'b1, 32'h10, 32'hA5A5_0001); #1;
    vecs++;
    if (req_ready !== 1'b1) begin errs++; $display("FAIL wr_ready: got %b expected 1", req_ready); end
    tick(); req_valid = 1'b0;
    vecs++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1010 || PADDR !== 32'h10 || PWDATA !== 32'hA5A5_0001) begin
      errs++; $display("FAIL wr_setup: got ctl=%b addr=%h data=%h expected 1010/10/a5a50001",
                       {PSEL, PENABLE, PWRITE, rsp_valid}, PADDR, PWDATA);
    end
    #1;
    vecs++;
    if (req_ready !== 1'b0) begin errs++; $display("FAIL wr_setup_ready: got %b expected 0", req_ready); end
    tick();
    vecs++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1110) begin
      errs++; $display("FAIL wr_access: got %b expected 1110", {PSEL, PENABLE, PWRITE, rsp_valid});
    end
    tick();
    vecs++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== '0) begin
      errs++; $display("FAIL wr_rsp: got ctl=%b rdata=%h expected 0010/0", {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    vecs++;
    if (PADDR !== 32'h10 || PWDATA !== 32'hA5A5_0001) begin
      errs++; $display("FAIL wr_idle_hold: got %h/%h expected 10/a5a50001", PADDR, PWDATA);
    end
    tick();
    vecs++;
    if (rsp_valid !== 1'b0) begin errs++; $display("FAIL wr_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_read_wait;
    PREADY = 1'b0; PRDATA = '0;
    put_req(1'b0, 32'h10, 32'hDEAD_BEEF);
    tick(); req_valid = 1'b0;
    vecs++;
    if ({PSEL, PENABLE} !== 2'b10) begin errs++; $display("FAIL rd_setup: got %b expected 10", {PSEL, PENABLE}); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      vecs++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1100 || PADDR !== 32'h10) begin
        errs++; $display("FAIL rd_access_%0d: got ctl=%b addr=%h expected 1100/10", i, {PSEL, PENABLE, PWRITE, rsp_valid}, PADDR);
      end
      if (i == 4) begin PREADY = 1'b1; PRDATA = 32'hA5A5_0001; end
      #1;
      vecs++;
      if (req_ready !== (i == 4)) begin
        errs++; $display("FAIL rd_ready_%0d: got %b expected %b", i, req_ready, (i == 4));
      end
      tick();
    end
    vecs++;
    if ({PSEL, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'hA5A5_0001) begin
      errs++; $display("FAIL rd_rsp: got ctl=%b rdata=%h expected 010/a5a50001", {PSEL, rsp_valid, rsp_err}, rsp_rdata);
    end
    PRDATA = '0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic        e_psel [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        e_pen  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        e_rsp  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_addr [7] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'h8};
    PREADY = 1'b1;
    put_req(1'b1, 32'h0, 32'hB0B0_0000);
    tick();
    for (int k = 0; k < 7; k++) begin
      vecs++;
      if ({PSEL, PENABLE, rsp_valid} !== {e_psel[k], e_pen[k], e_rsp[k]} || PADDR !== e_addr[k] ||
          PWDATA !== (32'hB0B0_0000 | e_addr[k]) || (rsp_valid && rsp_rdata !== '0)) begin
        errs++; $display("FAIL b2b_step%0d: got ctl=%b addr=%h data=%h rdata=%h expected ctl=%b addr=%h", k,
                         {PSEL, PENABLE, rsp_valid}, PADDR, PWDATA, rsp_rdata,
                         {e_psel[k], e_pen[k], e_rsp[k]}, e_addr[k]);
      end
      if (k == 0) put_req(1'b1, 32'h4, 32'hB0B0_0004);
      if (k == 2) put_req(1'b1, 32'h8, 32'hB0B0_0008);
      if (k == 4) req_valid = 1'b0;
      if (k < 6) tick();
    end
    tick();
  endtask

  task automatic test_slverr;
    PREADY = 1'b1;
    put_req(1'b1, 32'h20, 32'h0BAD_0020);
    tick(); req_valid = 1'b0; PSLVERR = 1'b1;
    tick(); tick();
    vecs++;
    if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== '0) begin
      errs++; $display("FAIL err_rsp: got %b rdata=%h expected 11/0", {rsp_valid, rsp_err}, rsp_rdata);
    end
    PSLVERR = 1'b0;
    tick();
    vecs++;
    if ({rsp_valid, rsp_err} !== 2'b00) begin
      errs++; $display("FAIL err_pulse: got %b expected 00", {rsp_valid, rsp_err});
    end
    PRDATA = 32'h1234_5678;
    put_req(1'b0, 32'h24, 32'h0);
    tick(); req_valid = 1'b0;
    tick(); tick();
    vecs++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h1234_5678) begin
      errs++; $display("FAIL err_next: got %b rdata=%h expected 10/12345678", {rsp_valid, rsp_err}, rsp_rdata);
    end
    PRDATA = '0;
    tick();
  endtask

  task automatic test_timeout;
`ifdef APB_TIMEOUT_EN
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
    put_req(1'b0, 32'h30, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      vecs++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
        errs++; $display("FAIL to_wait_%0d: got %b expected 110", i, {PSEL, PENABLE, rsp_valid});
      end
      tick();
    end
    vecs++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== '0) begin
      errs++; $display("FAIL to_abort: got ctl=%b rdata=%h expected 0011/0", {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    vecs++;
    if (rsp_valid !== 1'b0) begin errs++; $display("FAIL to_pulse: got %b expected 0", rsp_valid); end
    put_req(1'b0, 32'h34, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) PREADY = 1'b1;
      tick();
    end
    vecs++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 32'h5555_AAAA) begin
      errs++; $display("FAIL to_ready_at_limit: got ctl=%b rdata=%h expected 0010/5555aaaa",
                       {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
`else
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
    put_req(1'b0, 32'h30, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) begin
      vecs++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
        errs++; $display("FAIL nto_wait_%0d: got %b expected 110", i, {PSEL, PENABLE, rsp_valid});
      end
      if (i == 15) PREADY = 1'b1;
      tick();
    end
    vecs++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 32'h5555_AAAA) begin
      errs++; $display("FAIL nto_done: got ctl=%b rdata=%h expected 0010/5555aaaa",
                       {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
`endif
    PRDATA = '0; PREADY = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid;
    PREADY = 1'b0;
    put_req(1'b1, 32'h40, 32'h4040_4040);
    tick(); req_valid = 1'b0;
    tick(); tick();
    PRESET = 1'b1;
    tick();
    vecs++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
      errs++; $display("FAIL rst_mid_bus: got %b expected 000", {PSEL, PENABLE, rsp_valid});
    end
    #1;
    vecs++;
    if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_mid_ready: got %b expected 0", req_ready); end
    PRESET = 1'b0; PREADY = 1'b1;
    tick();
    vecs++;
    if (rsp_valid !== 1'b0 || PADDR !== '0) begin
      errs++; $display("FAIL rst_mid_norsp: got valid=%b addr=%h expected 0/0", rsp_valid, PADDR);
    end
    PRDATA = 32'h4444_0044;
    put_req(1'b0, 32'h44, 32'h0);
    tick(); req_valid = 1'b0;
    vecs++;
    if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 32'h44) begin
      errs++; $display("FAIL rst_after_setup: got ctl=%b addr=%h expected 10/44", {PSEL, PENABLE}, PADDR);
    end
    tick(); tick();
    vecs++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h4444_0044) begin
      errs++; $display("FAIL rst_after_rsp: got %b rdata=%h expected 10/44440044", {rsp_valid, rsp_err}, rsp_rdata);
    end
    PRDATA = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
